// File: rtl/lane_writeback_pkg.sv
// Lane writeback shared definitions: default parameters, FSM state encoding
// and the VRF write-entry payload at default widths.
package lane_writeback_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_QUEUE_DEPTH = 4;
   localparam int unsigned DEF_VD_WIDTH    = 5;
   localparam int unsigned DEF_GROUP_WIDTH = 5;
   localparam int unsigned DEF_IDX_WIDTH   = 3;
   localparam int unsigned DEF_MASK_WIDTH  = DEF_DATA_WIDTH / 8;

   // IDLE accepts new results; CROSS_HI holds the second widened beat.
   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      CROSS_HI = 1'b1
   } wbState_e;

   // One queued VRF write at default widths.
   typedef struct packed {
      logic [DEF_VD_WIDTH-1:0]   vd;
      logic                      offset;
      logic [DEF_MASK_WIDTH-1:0] mask;
      logic [DEF_DATA_WIDTH-1:0] data;
      logic                      last;
      logic [DEF_IDX_WIDTH-1:0]  instructionIndex;
   } writeEntry_t;

endpackage

// File: rtl/lane_writeback_if.sv
// Lane writeback bus: upstream result handshake plus VRF write request.
//   master : drives enqueue_* and vrfWriteRequest_ready (producer / VRF side)
//   slave  : the writeback stage itself
interface lane_writeback_if
   import lane_writeback_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned VD_WIDTH    = DEF_VD_WIDTH,
   parameter int unsigned GROUP_WIDTH = DEF_GROUP_WIDTH,
   parameter int unsigned IDX_WIDTH   = DEF_IDX_WIDTH
);
   localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

   logic                   enqueue_valid;
   logic                   enqueue_ready;
   logic [GROUP_WIDTH-1:0] enqueue_bits_groupCounter;
   logic [VD_WIDTH-1:0]    enqueue_bits_vd;
   logic [IDX_WIDTH-1:0]   enqueue_bits_instructionIndex;
   logic                   enqueue_bits_last;
   logic [DATA_WIDTH-1:0]  enqueue_bits_data;
   logic [MASK_WIDTH-1:0]  enqueue_bits_mask;
   logic                   enqueue_bits_crossWrite;
   logic [DATA_WIDTH-1:0]  enqueue_bits_crossWriteData_0;
   logic [DATA_WIDTH-1:0]  enqueue_bits_crossWriteData_1;

   logic                   vrfWriteRequest_valid;
   logic                   vrfWriteRequest_ready;
   logic [VD_WIDTH-1:0]    vrfWriteRequest_bits_vd;
   logic                   vrfWriteRequest_bits_offset;
   logic [MASK_WIDTH-1:0]  vrfWriteRequest_bits_mask;
   logic [DATA_WIDTH-1:0]  vrfWriteRequest_bits_data;
   logic                   vrfWriteRequest_bits_last;
   logic [IDX_WIDTH-1:0]   vrfWriteRequest_bits_instructionIndex;

   modport master (
      output enqueue_valid, enqueue_bits_groupCounter, enqueue_bits_vd,
             enqueue_bits_instructionIndex, enqueue_bits_last, enqueue_bits_data,
             enqueue_bits_mask, enqueue_bits_crossWrite,
             enqueue_bits_crossWriteData_0, enqueue_bits_crossWriteData_1,
             vrfWriteRequest_ready,
      input  enqueue_ready, vrfWriteRequest_valid, vrfWriteRequest_bits_vd,
             vrfWriteRequest_bits_offset, vrfWriteRequest_bits_mask,
             vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
             vrfWriteRequest_bits_instructionIndex
   );

   modport slave (
      input  enqueue_valid, enqueue_bits_groupCounter, enqueue_bits_vd,
             enqueue_bits_instructionIndex, enqueue_bits_last, enqueue_bits_data,
             enqueue_bits_mask, enqueue_bits_crossWrite,
             enqueue_bits_crossWriteData_0, enqueue_bits_crossWriteData_1,
             vrfWriteRequest_ready,
      output enqueue_ready, vrfWriteRequest_valid, vrfWriteRequest_bits_vd,
             vrfWriteRequest_bits_offset, vrfWriteRequest_bits_mask,
             vrfWriteRequest_bits_data, vrfWriteRequest_bits_last,
             vrfWriteRequest_bits_instructionIndex
   );

endinterface

// File: rtl/lane_write_queue.sv
// In-order circular write queue, no flow-through.
//   clock, reset     : clock, async active-low reset
//   push / pushEntry : write an entry (ignored when full)
//   pop              : retire the head (ignored when empty)
//   full, empty      : occupancy flags
//   count            : occupied entries, 0..DEPTH
//   head             : oldest entry, read straight from storage
module lane_write_queue
   import lane_writeback_pkg::*;
#(
   parameter int unsigned DEPTH   = DEF_QUEUE_DEPTH,
   parameter type         entry_t = writeEntry_t
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 push,
   input  entry_t               pushEntry,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(DEPTH):0] count,
   output entry_t               head
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   entry_t           storage [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] occupancy;
   logic             doPush;
   logic             doPop;

   assign full   = (occupancy == CNT_W'(DEPTH));
   assign empty  = (occupancy == '0);
   assign doPush = push && !full;
   assign doPop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) storage[i] <= '0;
      end else begin
         if (doPush) begin
            storage[wrPtr] <= pushEntry;
            wrPtr          <= wrPtr + PTR_W'(1);
         end
         if (doPop) rdPtr <= rdPtr + PTR_W'(1);
         if (doPush && !doPop)      occupancy <= occupancy + CNT_W'(1);
         else if (doPop && !doPush) occupancy <= occupancy - CNT_W'(1);
      end
   end

   assign count = occupancy;
   assign head  = storage[rdPtr];

endmodule

// File: rtl/lane_writeback_stage.sv
// Lane writeback stage: turns lane results (normal or widened two-beat
// crossWrite) into VRF write requests through an in-order queue, and tracks
// which instruction indices still have writes in flight.
//   clock, reset : clock, async active-low reset
//   bus          : enqueue_* upstream handshake, vrfWriteRequest_* VRF side
//   queueCount   : occupied queue entries
//   pendingMask  : bit i set while instruction i has a queued or held write
module lane_writeback_stage
   import lane_writeback_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned QUEUE_DEPTH = DEF_QUEUE_DEPTH,
   parameter int unsigned VD_WIDTH    = DEF_VD_WIDTH,
   parameter int unsigned GROUP_WIDTH = DEF_GROUP_WIDTH,
   parameter int unsigned IDX_WIDTH   = DEF_IDX_WIDTH
) (
   input  logic                          clock,
   input  logic                          reset,
   lane_writeback_if.slave               bus,
   output logic [$clog2(QUEUE_DEPTH):0]  queueCount,
   output logic [(2**IDX_WIDTH)-1:0]     pendingMask
);
   localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned NUM_IDX    = 2 ** IDX_WIDTH;
   localparam int unsigned ICNT_W     = $clog2(QUEUE_DEPTH + 1) + 1;

   typedef struct packed {
      logic [VD_WIDTH-1:0]   vd;
      logic                  offset;
      logic [MASK_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
      logic [IDX_WIDTH-1:0]  instructionIndex;
   } entry_t;

   wbState_e          state;
   wbState_e          nextState;
   entry_t            holdEntry;
   entry_t            pushEntry;
   entry_t            headEntry;
   entry_t            normalEntry;
   entry_t            beat0Entry;
   entry_t            beat1Entry;
   logic              push;
   logic              pop;
   logic              loadHold;
   logic              enqReady;
   logic              qFull;
   logic              qEmpty;
   logic [NUM_IDX-1:0] incVec;
   logic [NUM_IDX-1:0] decVec;
   logic [ICNT_W-1:0] idxCount [NUM_IDX];

   // Register address = vd + (counter >> 1), wrapping; offset = counter LSB.
   function automatic entry_t makeEntry(
      input logic [VD_WIDTH-1:0]   vd,
      input logic [VD_WIDTH-1:0]   step,
      input logic                  offset,
      input logic [MASK_WIDTH-1:0] mask,
      input logic [DATA_WIDTH-1:0] data,
      input logic                  last,
      input logic [IDX_WIDTH-1:0]  idx
   );
      entry_t e;
      e.vd               = vd + step;
      e.offset           = offset;
      e.mask             = mask;
      e.data             = data;
      e.last             = last;
      e.instructionIndex = idx;
      return e;
   endfunction

   // Candidate entries; crossWrite counter is {groupCounter, beat}.
   always_comb begin
      normalEntry = makeEntry(bus.enqueue_bits_vd,
                              VD_WIDTH'(bus.enqueue_bits_groupCounter >> 1),
                              bus.enqueue_bits_groupCounter[0],
                              bus.enqueue_bits_mask, bus.enqueue_bits_data,
                              bus.enqueue_bits_last, bus.enqueue_bits_instructionIndex);
      beat0Entry  = makeEntry(bus.enqueue_bits_vd,
                              VD_WIDTH'(bus.enqueue_bits_groupCounter), 1'b0,
                              bus.enqueue_bits_mask, bus.enqueue_bits_crossWriteData_0,
                              1'b0, bus.enqueue_bits_instructionIndex);
      beat1Entry  = makeEntry(bus.enqueue_bits_vd,
                              VD_WIDTH'(bus.enqueue_bits_groupCounter), 1'b1,
                              bus.enqueue_bits_mask, bus.enqueue_bits_crossWriteData_1,
                              bus.enqueue_bits_last, bus.enqueue_bits_instructionIndex);
   end

   // State and hold register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         holdEntry <= '0;
      end else begin
         state <= nextState;
         if (loadHold) holdEntry <= beat1Entry;
      end
   end

   // Next state, enqueue handshake and push selection.
   always_comb begin
      nextState = state;
      enqReady  = 1'b0;
      push      = 1'b0;
      pushEntry = '0;
      loadHold  = 1'b0;
      case (state)
         IDLE: begin
            enqReady = !qFull;
            if (bus.enqueue_valid && !qFull) begin
               push = 1'b1;
               if (bus.enqueue_bits_crossWrite) begin
                  pushEntry = beat0Entry;
                  loadHold  = 1'b1;
                  nextState = CROSS_HI;
               end else begin
                  pushEntry = normalEntry;
               end
            end
         end
         CROSS_HI: begin
            if (!qFull) begin
               push      = 1'b1;
               pushEntry = holdEntry;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign pop = !qEmpty && bus.vrfWriteRequest_ready;

   lane_write_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .entry_t (entry_t)
   ) uQueue (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .pushEntry (pushEntry),
      .pop       (pop),
      .full      (qFull),
      .empty     (qEmpty),
      .count     (queueCount),
      .head      (headEntry)
   );

   // Per-index push/pop strobes.
   always_comb begin
      incVec = '0;
      decVec = '0;
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
         incVec[i] = push && (pushEntry.instructionIndex == IDX_WIDTH'(i));
         decVec[i] = pop && (headEntry.instructionIndex == IDX_WIDTH'(i));
      end
   end

   // Outstanding-write counters; simultaneous push and pop cancel.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_IDX; i++) idxCount[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_IDX; i++) begin
            if (incVec[i] && !decVec[i])      idxCount[i] <= idxCount[i] + ICNT_W'(1);
            else if (decVec[i] && !incVec[i]) idxCount[i] <= idxCount[i] - ICNT_W'(1);
         end
      end
   end

   // The held beat1 is not yet counted, so it contributes directly.
   always_comb begin
      pendingMask = '0;
      for (int unsigned i = 0; i < NUM_IDX; i++) begin
         pendingMask[i] = (idxCount[i] != '0) ||
                          ((state == CROSS_HI) && (holdEntry.instructionIndex == IDX_WIDTH'(i)));
      end
   end

   assign bus.enqueue_ready                        = enqReady;
   assign bus.vrfWriteRequest_valid                = !qEmpty;
   assign bus.vrfWriteRequest_bits_vd              = headEntry.vd;
   assign bus.vrfWriteRequest_bits_offset          = headEntry.offset;
   assign bus.vrfWriteRequest_bits_mask            = headEntry.mask;
   assign bus.vrfWriteRequest_bits_data            = headEntry.data;
   assign bus.vrfWriteRequest_bits_last            = headEntry.last;
   assign bus.vrfWriteRequest_bits_instructionIndex = headEntry.instructionIndex;

endmodule

// File: tb/tb_lane_writeback_stage.sv
// Directed bench for lane_writeback_stage at default parameters.
module tb_lane_writeback_stage;

   logic       clock;
   logic       reset;
   logic [2:0] queueCount;
   logic [7:0] pendingMask;
   int         checks;
   int         failures;

   lane_writeback_if bus ();

   lane_writeback_stage dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .queueCount  (queueCount),
      .pendingMask (pendingMask)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [4:0]  vd;
      logic [4:0]  gc;
      logic [31:0] data;
      logic [3:0]  mask;
      logic        last;
      logic [2:0]  idx;
      logic [4:0]  expVd;
      logic        expOff;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic setIdle();
      bus.enqueue_valid                 = 1'b0;
      bus.enqueue_bits_crossWrite       = 1'b0;
      bus.enqueue_bits_groupCounter     = '0;
      bus.enqueue_bits_vd               = '0;
      bus.enqueue_bits_instructionIndex = '0;
      bus.enqueue_bits_last             = 1'b0;
      bus.enqueue_bits_data             = '0;
      bus.enqueue_bits_mask             = '0;
      bus.enqueue_bits_crossWriteData_0 = '0;
      bus.enqueue_bits_crossWriteData_1 = '0;
   endtask

   task automatic setNormal(input logic [4:0] vd, input logic [4:0] gc, input logic [31:0] data,
                            input logic [3:0] mask, input logic last, input logic [2:0] idx);
      setIdle();
      bus.enqueue_valid                 = 1'b1;
      bus.enqueue_bits_vd               = vd;
      bus.enqueue_bits_groupCounter     = gc;
      bus.enqueue_bits_data             = data;
      bus.enqueue_bits_mask             = mask;
      bus.enqueue_bits_last             = last;
      bus.enqueue_bits_instructionIndex = idx;
   endtask

   task automatic setCross(input logic [4:0] vd, input logic [4:0] gc, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [3:0] mask, input logic last,
                           input logic [2:0] idx);
      setNormal(vd, gc, 32'h0, mask, last, idx);
      bus.enqueue_bits_crossWrite       = 1'b1;
      bus.enqueue_bits_crossWriteData_0 = d0;
      bus.enqueue_bits_crossWriteData_1 = d1;
   endtask

   task automatic checkHead(input string name, input logic [4:0] vd, input logic off,
                            input logic [31:0] data, input logic last, input logic [2:0] idx);
      check({name, " valid"}, bus.vrfWriteRequest_valid, 1);
      check({name, " vd"},    bus.vrfWriteRequest_bits_vd, vd);
      check({name, " off"},   bus.vrfWriteRequest_bits_offset, off);
      check({name, " data"},  bus.vrfWriteRequest_bits_data, data);
      check({name, " last"},  bus.vrfWriteRequest_bits_last, last);
      check({name, " idx"},   bus.vrfWriteRequest_bits_instructionIndex, idx);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      int rcvd;
      logic [31:0] expQ [$];
      logic [31:0] expData;

      checks   = 0;
      failures = 0;
      vecs[0] = '{5'd3,  5'd5,  32'hDEADBEEF, 4'hF, 1'b0, 3'd1, 5'd5,  1'b1};
      vecs[1] = '{5'd31, 5'd4,  32'h12345678, 4'h3, 1'b1, 3'd2, 5'd1,  1'b0};
      vecs[2] = '{5'd0,  5'd0,  32'h00000001, 4'h1, 1'b0, 3'd0, 5'd0,  1'b0};
      vecs[3] = '{5'd10, 5'd31, 32'hCAFEF00D, 4'h8, 1'b1, 3'd7, 5'd25, 1'b1};
      vecs[4] = '{5'd30, 5'd7,  32'hFFFFFFFF, 4'hC, 1'b0, 3'd4, 5'd1,  1'b1};
      vecs[5] = '{5'd17, 5'd12, 32'hA5A55A5A, 4'h6, 1'b1, 3'd6, 5'd23, 1'b0};

      // Reset state
      reset = 1'b0;
      setIdle();
      bus.vrfWriteRequest_ready = 1'b0;
      #3;
      check("rst ready",   bus.enqueue_ready, 1);
      check("rst valid",   bus.vrfWriteRequest_valid, 0);
      check("rst vd",      bus.vrfWriteRequest_bits_vd, 0);
      check("rst data",    bus.vrfWriteRequest_bits_data, 0);
      check("rst mask",    bus.vrfWriteRequest_bits_mask, 0);
      check("rst offlast", {bus.vrfWriteRequest_bits_offset, bus.vrfWriteRequest_bits_last}, 0);
      check("rst idx",     bus.vrfWriteRequest_bits_instructionIndex, 0);
      check("rst count",   queueCount, 0);
      check("rst pending", pendingMask, 0);
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b1;
      tick();

      // Normal writes, one at a time, VRF always ready
      bus.vrfWriteRequest_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         setNormal(vecs[i].vd, vecs[i].gc, vecs[i].data, vecs[i].mask, vecs[i].last, vecs[i].idx);
         #1;
         check("vec ready", bus.enqueue_ready, 1);
         check("vec no flow-through", bus.vrfWriteRequest_valid, 0);
         tick();
         setIdle();
         checkHead("vec", vecs[i].expVd, vecs[i].expOff, vecs[i].data, vecs[i].last, vecs[i].idx);
         check("vec mask", bus.vrfWriteRequest_bits_mask, vecs[i].mask);
         check("vec count", queueCount, 1);
         tick();
         check("vec drained", bus.vrfWriteRequest_valid, 0);
         check("vec pending", pendingMask, 0);
      end

      // CrossWrite: two beats in order, one cycle of enqueue_ready low
      setCross(5'd0, 5'd2, 32'h11, 32'h22, 4'hF, 1'b1, 3'd3);
      tick();
      setIdle();
      check("cross ready low", bus.enqueue_ready, 0);
      checkHead("cross beat0", 5'd2, 1'b0, 32'h11, 1'b0, 3'd3);
      check("cross pending hi", pendingMask, 8'h08);
      tick();
      check("cross ready back", bus.enqueue_ready, 1);
      checkHead("cross beat1", 5'd2, 1'b1, 32'h22, 1'b1, 3'd3);
      check("cross count", queueCount, 1);
      tick();
      check("cross drained", bus.vrfWriteRequest_valid, 0);
      check("cross pending", pendingMask, 0);

      // Backpressure: fill, then a pop with a refused push
      bus.vrfWriteRequest_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         setNormal(5'd0, 5'd0, 32'hA0 + 32'(k), 4'hF, 1'b0, 3'd1);
         #1;
         check("bp fill ready", bus.enqueue_ready, 1);
         tick();
      end
      setIdle();
      check("bp full count", queueCount, 4);
      check("bp full ready", bus.enqueue_ready, 0);
      bus.vrfWriteRequest_ready = 1'b1;
      setNormal(5'd0, 5'd0, 32'h99, 4'hF, 1'b0, 3'd1);
      #1;
      check("bp ready indep", bus.enqueue_ready, 0);
      tick();
      setIdle();
      check("bp refused count", queueCount, 3);
      check("bp head1", bus.vrfWriteRequest_bits_data, 32'hA1);
      tick();
      check("bp head2", bus.vrfWriteRequest_bits_data, 32'hA2);
      tick();
      check("bp head3", bus.vrfWriteRequest_bits_data, 32'hA3);
      tick();
      check("bp empty", bus.vrfWriteRequest_valid, 0);
      check("bp empty count", queueCount, 0);

      // Stream 10 writes with a stalling VRF; pointers wrap
      sent = 0;
      rcvd = 0;
      for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
         bus.vrfWriteRequest_ready = ((cyc % 3) != 2);
         if (sent < 10) setNormal(5'd31, 5'd4, 32'h200 + 32'(sent), 4'hF, sent == 9, 3'(sent));
         else setIdle();
         #1;
         if (bus.vrfWriteRequest_valid && bus.vrfWriteRequest_ready) begin
            if (expQ.size() == 0) begin
               check("stream spurious pop", 1, 0);
            end else begin
               expData = expQ.pop_front();
               check("stream data", bus.vrfWriteRequest_bits_data, expData);
               check("stream vd", bus.vrfWriteRequest_bits_vd, 5'd1);
            end
            rcvd++;
         end
         if (bus.enqueue_valid && bus.enqueue_ready) begin
            expQ.push_back(32'h200 + 32'(sent));
            sent++;
         end
         tick();
      end
      setIdle();
      check("stream received", rcvd, 10);
      check("stream count", queueCount, 0);
      check("stream pending", pendingMask, 0);

      // Pending mask tracking
      bus.vrfWriteRequest_ready = 1'b0;
      setNormal(5'd1, 5'd0, 32'h2, 4'hF, 1'b0, 3'd2);
      tick();
      setNormal(5'd1, 5'd0, 32'h5, 4'hF, 1'b0, 3'd5);
      tick();
      setIdle();
      check("pend both", pendingMask, 8'h24);
      bus.vrfWriteRequest_ready = 1'b1;
      tick();
      check("pend after pop2", pendingMask, 8'h20);
      tick();
      check("pend after pop5", pendingMask, 8'h00);

      // Reset while holding beat1 with three entries queued
      bus.vrfWriteRequest_ready = 1'b0;
      setNormal(5'd0, 5'd0, 32'h31, 4'hF, 1'b0, 3'd1);
      tick();
      setNormal(5'd0, 5'd0, 32'h32, 4'hF, 1'b0, 3'd4);
      tick();
      setCross(5'd0, 5'd2, 32'h41, 32'h42, 4'hF, 1'b1, 3'd6);
      tick();
      setIdle();
      check("prerst count", queueCount, 3);
      check("prerst ready", bus.enqueue_ready, 0);
      check("prerst pending", pendingMask, 8'h52);
      reset = 1'b0;
      #1;
      check("midrst valid", bus.vrfWriteRequest_valid, 0);
      check("midrst count", queueCount, 0);
      check("midrst pending", pendingMask, 0);
      check("midrst ready", bus.enqueue_ready, 1);
      check("midrst data", bus.vrfWriteRequest_bits_data, 0);
      tick();
      reset = 1'b1;
      bus.vrfWriteRequest_ready = 1'b1;
      tick();
      tick();
      check("postrst valid", bus.vrfWriteRequest_valid, 0);
      check("postrst count", queueCount, 0);
      check("postrst pending", pendingMask, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lane_writeback_stage.md
LANE_WRITEBACK_STAGE -- requirements
Module: lane_writeback_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning VRF write data width; MASK_WIDTH = DATA_WIDTH/8.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 4, meaning write-queue entries; must be a power of two, at least 2.
REQ-003 SHALL have parameter VD_WIDTH, default 5, meaning register index width.
REQ-004 SHALL have parameter GROUP_WIDTH, default 5, meaning group counter width.
REQ-005 SHALL have parameter IDX_WIDTH, default 3, meaning instruction index width.
REQ-006 SHALL have port clock, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have ports enqueue_valid (input, 1) and enqueue_ready (output, 1): upstream handshake.
REQ-009 SHALL have ports enqueue_bits_groupCounter (input, GROUP_WIDTH), enqueue_bits_vd (input, VD_WIDTH), enqueue_bits_instructionIndex (input, IDX_WIDTH), enqueue_bits_last (input, 1): last group of the instruction.
REQ-010 SHALL have ports enqueue_bits_data (input, DATA_WIDTH) and enqueue_bits_mask (input, MASK_WIDTH): normal result.
REQ-011 SHALL have ports enqueue_bits_crossWrite (input, 1), enqueue_bits_crossWriteData_0 and enqueue_bits_crossWriteData_1 (input, DATA_WIDTH each): widened two-beat result.
REQ-012 SHALL have ports vrfWriteRequest_valid (output, 1) and vrfWriteRequest_ready (input, 1): VRF handshake.
REQ-013 SHALL have ports vrfWriteRequest_bits_vd (output, VD_WIDTH), _offset (output, 1), _mask (output, MASK_WIDTH), _data (output, DATA_WIDTH), _last (output, 1) and _instructionIndex (output, IDX_WIDTH).
REQ-014 SHALL have port queueCount (output, clog2(QUEUE_DEPTH)+1): occupied entries.
REQ-015 SHALL have port pendingMask (output, 2^IDX_WIDTH): bit i set while any write of instruction i is queued or held.

Function
REQ-016 SHALL compute write address from counter c: vd_out = (vd + (c >> 1)) mod 2^VD_WIDTH, and offset = c[0].
REQ-017 Normal (crossWrite=0) SHALL push one entry: c = groupCounter, data, mask, last = enqueue_bits_last.
REQ-018 CrossWrite SHALL produce two entries in order. Beat0: c = {groupCounter,0}, data = crossWriteData_0, last = 0. Beat1: c = {groupCounter,1}, data = crossWriteData_1, last = enqueue_bits_last. Both beats use enqueue_bits_mask.
REQ-019 SHALL use an FSM with states IDLE and CROSS_HI; reset enters IDLE.
REQ-020 In IDLE, enqueue_ready SHALL equal !queueFull.
REQ-021 On a crossWrite accept in IDLE, the block SHALL push beat0, latch beat1 in a hold register, and enter CROSS_HI.
REQ-022 In CROSS_HI, enqueue_ready SHALL be 0; beat1 SHALL be pushed when the queue is not full, then the FSM SHALL return to IDLE.
REQ-023 The queue SHALL be a circular buffer, in-order, with no flow-through: an entry pushed at cycle t is first visible at the output at t+1.
REQ-024 vrfWriteRequest_valid SHALL equal !queueEmpty; a pop occurs on valid && ready.
REQ-025 Full queue with a simultaneous pop SHALL still refuse the push that cycle; ready SHALL not depend on vrfWriteRequest_ready.
REQ-026 Empty queue SHALL never pop; output bits are don't-care while valid is 0 but SHALL be stable.
REQ-027 Read and write pointers SHALL wrap modulo QUEUE_DEPTH; queueCount SHALL range 0..QUEUE_DEPTH.
REQ-028 Each instruction index SHALL have a counter, width clog2(QUEUE_DEPTH+1)+1: +1 per push, -1 per pop; same-index push and pop in one cycle nets 0.
REQ-029 pendingMask[i] SHALL equal (counter_i != 0) OR (FSM in CROSS_HI AND held index == i).
REQ-030 Output bits SHALL be driven straight from queue-head storage, with no combinational path from enqueue inputs.

Reset
REQ-031 Reset assertion SHALL asynchronously clear pointers, counts, index counters, hold register and storage, and set the FSM to IDLE.
REQ-032 During and after reset: enqueue_ready = 1, vrfWriteRequest_valid = 0, all vrfWriteRequest_bits = 0, queueCount = 0, pendingMask = 0.
REQ-033 Reset mid-crossWrite SHALL discard the held beat1.

Structure
REQ-034 Package lane_writeback_pkg SHALL hold the FSM state enum, the write-entry struct (vd, offset, mask, data, last, instructionIndex) and default parameter constants.
REQ-035 Sub-module lane_write_queue SHALL implement the parametrised circular FIFO (push, pop, full, empty, count, head).

Verification
REQ-036 Normal write: vd=3, groupCounter=5, data=0xDEADBEEF, mask=0xF, ready=1 -> next cycle valid=1, vd=5, offset=1, data=0xDEADBEEF.
REQ-037 CrossWrite: vd=0, groupCounter=2, data_0=0x11, data_1=0x22, last=1 -> two writes in order: (vd=2, off=0, 0x11, last=0) then (vd=2, off=1, 0x22, last=1); enqueue_ready=0 for one cycle.
REQ-038 Backpressure: vrfWriteRequest_ready=0, push 4 normal writes -> queueCount=4, enqueue_ready=0; one pop with push attempt -> push refused, count=3.
REQ-039 Wrap: vd=31, groupCounter=4 -> vd_out=1; stream 10 writes through DEPTH=4 -> all delivered in order.
REQ-040 Pending: push idx 2 and idx 5 -> pendingMask=0x24; pop idx 2 -> 0x20; pop idx 5 -> 0x00.
REQ-041 Reset asserted while in CROSS_HI with 3 entries queued -> immediately valid=0, count=0, pendingMask=0, enqueue_ready=1.
